// File: rtl/instr_fetch_responder_pkg.sv
// rtl/instr_fetch_responder_pkg.sv - shared constants and helpers for the instruction fetch responder
//
// Purpose : NOP substitute word, FSM state encodings, fault-code and latency-counter widths,
//           and the fetch fault predicate shared by the responder and its array.
// Ports   : none (package)

package instr_fetch_responder_pkg;

    // Word returned in place of the array contents when a fetch faults (addi x0, x0, 0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // FSM encodings, kept as plain constants so older tools and netlists see fixed codes.
    localparam int          STATE_W = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
    localparam logic [1:0]  ST_RESP = 2'd2;

    // A single fault bit today; widened here if fault causes ever need to be told apart.
    localparam int FAULT_W = 1;
    typedef logic [FAULT_W-1:0] fault_code_t;

    // Latency counter holds READ_LATENCY-1, which is at most 7.
    localparam int CNT_W = 4;

    // A fetch faults when the PC is not word aligned or the full word index lies beyond the
    // array. The full addr[31:2] is compared so high address bits can never wrap into range.
    function automatic logic fetch_is_fault(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/instr_fetch_responder_rom_array.sv
// rtl/instr_fetch_responder_rom_array.sv - DEPTH x 32 instruction array, one write port, one captured read port
//
// Purpose : Instruction storage. The write port is used for program preload; the read port
//           captures a word into rdata on the edge where re is high.
// Ports   : clk      rising-edge clock
//           reset_n  asynchronous active-low reset (clears rdata only, never the array)
//           we       write strobe
//           waddr    write word index
//           wdata    write data
//           re       capture strobe
//           raddr    read word index
//           rdata    captured word

module instr_rom_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    // Array contents survive reset so a preloaded program is kept across a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the pre-edge contents, so a write to the same word on the capture edge
    // is not seen by this read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 32'h0000_0000;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - memory end of the instruction fetch interface
//
// Purpose : Accepts a PC on fetch_req/fetch_ready, reads the instruction array, and returns
//           the word (or a NOP plus fault flag) READ_LATENCY cycles later on instr_valid/rsp_ready.
// Ports   : clk          rising-edge clock
//           reset_n      asynchronous active-low reset
//           fetch_req    fetch address valid
//           fetch_addr   byte address (PC), sampled only on accept
//           fetch_ready  request can be accepted this cycle (combinational from rsp_ready)
//           instr_valid  instr/fetch_fault valid
//           instr        fetched instruction, NOP_INSTR on a fault
//           fetch_fault  misaligned or out-of-range fetch
//           rsp_ready    consumer takes the response
//           load_en      program-load write strobe
//           load_addr    program-load word index
//           load_data    program-load word

module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_req,
    input  logic [31:0]              fetch_addr,
    output logic                     fetch_ready,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic                     fetch_fault,
    input  logic                     rsp_ready,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(READ_LATENCY - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    fault_code_t        fault_q;

    logic               accept;
    logic               fault_now;
    logic [AW-1:0]      word_idx;
    logic [31:0]        rom_rdata;

    assign fetch_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept      = fetch_req && fetch_ready;
    assign fault_now   = fetch_is_fault(fetch_addr, DEPTH);
    assign word_idx    = fetch_addr[2 +: AW];

    // The array captures the word on the accept edge; faulting fetches leave it untouched.
    instr_rom_array #(
        .DEPTH (DEPTH)
    ) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (load_en),
        .waddr   (load_addr),
        .wdata   (load_data),
        .re      (accept && !fault_now),
        .raddr   (word_idx),
        .rdata   (rom_rdata)
    );

    // Entry state after an accept: a one-cycle latency has no wait phase at all.
    function automatic logic [STATE_W-1:0] accept_target();
        return (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = accept_target();
                    cnt_d   = LOAD_CNT;
                end
            end
            ST_WAIT: begin
                // Leave on the edge where the counter reaches zero, so the response shows up
                // exactly READ_LATENCY cycles after the accept cycle.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (fetch_req) begin
                        state_d = accept_target();
                        cnt_d   = LOAD_CNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                fault_q <= fault_code_t'(fault_now);
            end
        end
    end

    // Response fields come straight from the captured word and fault bit, both of which only
    // change on an accept, so they stay stable for the whole response phase.
    assign instr_valid = (state_q == ST_RESP);
    assign fetch_fault = |fault_q;
    assign instr       = (|fault_q) ? NOP_INSTR : rom_rdata;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb/tb_instr_fetch_responder.sv - directed bench for instr_fetch_responder at latencies 2, 1 and 8

module tb_instr_fetch_responder;

    logic        clk;
    logic        reset_n;
    logic        fetch_req   [3];
    logic [31:0] fetch_addr  [3];
    logic        fetch_ready [3];
    logic        instr_valid [3];
    logic [31:0] instr       [3];
    logic        fetch_fault [3];
    logic        rsp_ready   [3];
    logic        load_en     [3];
    logic [7:0]  load_addr   [3];
    logic [31:0] load_data   [3];

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_responder #(.DEPTH(256), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
        .fetch_ready(fetch_ready[0]), .instr_valid(instr_valid[0]), .instr(instr[0]),
        .fetch_fault(fetch_fault[0]), .rsp_ready(rsp_ready[0]), .load_en(load_en[0]),
        .load_addr(load_addr[0]), .load_data(load_data[0])
    );

    instr_fetch_responder #(.DEPTH(256), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
        .fetch_ready(fetch_ready[1]), .instr_valid(instr_valid[1]), .instr(instr[1]),
        .fetch_fault(fetch_fault[1]), .rsp_ready(rsp_ready[1]), .load_en(load_en[1]),
        .load_addr(load_addr[1]), .load_data(load_data[1])
    );

    instr_fetch_responder #(.DEPTH(256), .READ_LATENCY(8)) u_dut_l8 (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req[2]), .fetch_addr(fetch_addr[2]),
        .fetch_ready(fetch_ready[2]), .instr_valid(instr_valid[2]), .instr(instr[2]),
        .fetch_fault(fetch_fault[2]), .rsp_ready(rsp_ready[2]), .load_en(load_en[2]),
        .load_addr(load_addr[2]), .load_data(load_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int d, input logic [7:0] a, input logic [31:0] data);
        load_en[d]   = 1'b1;
        load_addr[d] = a;
        load_data[d] = data;
        tick();
        load_en[d]   = 1'b0;
    endtask

    // Holds fetch_req until accepted; returns with the accept edge just passed.
    task automatic issue(input int d, input logic [31:0] addr, input string tag);
        int n;
        fetch_req[d]  = 1'b1;
        fetch_addr[d] = addr;
        n = 0;
        while (!fetch_ready[d] && n < 20) begin
            tick();
            n++;
        end
        check_eq($sformatf("L%0d %s ready", lat(d), tag), 32'(fetch_ready[d]), 32'd1);
        tick();
        fetch_req[d] = 1'b0;
    endtask

    // Called in the cycle after the accept edge; checks latency and the response contents.
    task automatic wait_rsp(input int d, input logic [31:0] exp_instr, input logic exp_fault,
                            input string tag);
        int k;
        k = 1;
        while (!instr_valid[d] && k < 30) begin
            tick();
            k++;
        end
        check_eq($sformatf("L%0d %s latency", lat(d), tag), 32'(k), 32'(lat(d)));
        check_eq($sformatf("L%0d %s instr", lat(d), tag), instr[d], exp_instr);
        check_eq($sformatf("L%0d %s fault", lat(d), tag), 32'(fetch_fault[d]), 32'(exp_fault));
    endtask

    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_instr,
                         input logic exp_fault, input string tag);
        issue(d, addr, tag);
        wait_rsp(d, exp_instr, exp_fault, tag);
        tick();
        check_eq($sformatf("L%0d %s drop", lat(d), tag), 32'(instr_valid[d]), 32'd0);
    endtask

    task automatic test_backpressure(input int d);
        rsp_ready[d]  = 1'b0;
        issue(d, 32'h0000_000C, "bp1");
        fetch_req[d]  = 1'b1;
        fetch_addr[d] = 32'h0000_0010;
        wait_rsp(d, 32'h0050_0093, 1'b0, "bp1");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("L%0d bp hold valid %0d", lat(d), i), 32'(instr_valid[d]), 32'd1);
            check_eq($sformatf("L%0d bp hold instr %0d", lat(d), i), instr[d], 32'h0050_0093);
            check_eq($sformatf("L%0d bp ready low %0d", lat(d), i), 32'(fetch_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        #1;
        check_eq($sformatf("L%0d bp ready high", lat(d)), 32'(fetch_ready[d]), 32'd1);
        tick();
        fetch_req[d] = 1'b0;
        check_eq($sformatf("L%0d bp b2b valid", lat(d)), 32'(instr_valid[d]),
                 32'(lat(d) == 1));
        wait_rsp(d, 32'h1111_2222, 1'b0, "bp2");
        tick();
    endtask

    task automatic test_b2b(input int d);
        logic [31:0] exp_w [3];
        int acc, rsp, last_acc, cyc;
        logic a;
        exp_w[0] = 32'hA000_0000;
        exp_w[1] = 32'hA000_0001;
        exp_w[2] = 32'hA000_0002;
        acc = 0; rsp = 0; last_acc = 0; cyc = 0;
        fetch_req[d]  = 1'b1;
        fetch_addr[d] = 32'h0000_0000;
        while (rsp < 3 && cyc < 80) begin
            if (instr_valid[d]) begin
                check_eq($sformatf("L%0d b2b rsp %0d", lat(d), rsp), instr[d], exp_w[rsp]);
                rsp++;
            end
            a = fetch_req[d] && fetch_ready[d];
            if (a) begin
                if (acc > 0)
                    check_eq($sformatf("L%0d b2b spacing %0d", lat(d), acc),
                             32'(cyc - last_acc), 32'(lat(d)));
                last_acc = cyc;
                acc++;
            end
            tick();
            cyc++;
            if (a) begin
                if (acc == 3) fetch_req[d] = 1'b0;
                else          fetch_addr[d] = 32'(acc * 4);
            end
        end
        fetch_req[d] = 1'b0;
        check_eq($sformatf("L%0d b2b responses", lat(d)), 32'(rsp), 32'd3);
        check_eq($sformatf("L%0d b2b accepts", lat(d)), 32'(acc), 32'd3);
        tick();
        check_eq($sformatf("L%0d b2b idle", lat(d)), 32'(instr_valid[d]), 32'd0);
    endtask

    task automatic test_collision(input int d);
        fetch_req[d]  = 1'b1;
        fetch_addr[d] = 32'h0000_0010;
        load_en[d]    = 1'b1;
        load_addr[d]  = 8'd4;
        load_data[d]  = 32'hDEAD_BEEF;
        #1;
        check_eq($sformatf("L%0d coll ready", lat(d)), 32'(fetch_ready[d]), 32'd1);
        tick();
        fetch_req[d] = 1'b0;
        load_en[d]   = 1'b0;
        wait_rsp(d, 32'h1111_2222, 1'b0, "coll old");
        tick();
        // A write landing after the accept must not reach the captured word.
        issue(d, 32'h0000_0010, "inflight");
        load_en[d]   = 1'b1;
        load_addr[d] = 8'd4;
        load_data[d] = 32'h5555_5555;
        wait_rsp(d, 32'hDEAD_BEEF, 1'b0, "inflight");
        tick();
        load_en[d] = 1'b0;
        fetch(d, 32'h0000_0010, 32'h5555_5555, 1'b0, "after write");
    endtask

    task automatic test_reset(input int d);
        int seen;
        issue(d, 32'h0000_000C, "rst");
        reset_n = 1'b0;
        #1;
        check_eq($sformatf("L%0d rst valid", lat(d)), 32'(instr_valid[d]), 32'd0);
        check_eq($sformatf("L%0d rst ready", lat(d)), 32'(fetch_ready[d]), 32'd1);
        check_eq($sformatf("L%0d rst instr", lat(d)), instr[d], 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (instr_valid[d]) seen++;
            tick();
        end
        check_eq($sformatf("L%0d rst no rsp", lat(d)), 32'(seen), 32'd0);
        // Array contents survive reset.
        fetch(d, 32'h0000_000C, 32'h0050_0093, 1'b0, "post rst");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            fetch_req[d]  = 1'b0;
            fetch_addr[d] = 32'h0;
            rsp_ready[d]  = 1'b1;
            load_en[d]    = 1'b0;
            load_addr[d]  = 8'h0;
            load_data[d]  = 32'h0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("L%0d reset valid", lat(d)), 32'(instr_valid[d]), 32'd0);
            check_eq($sformatf("L%0d reset instr", lat(d)), instr[d], 32'd0);
            check_eq($sformatf("L%0d reset fault", lat(d)), 32'(fetch_fault[d]), 32'd0);
            check_eq($sformatf("L%0d reset ready", lat(d)), 32'(fetch_ready[d]), 32'd1);
        end
        reset_n = 1'b1;
        tick();

        for (int d = 0; d < 3; d++) begin
            load_word(d, 8'd3,   32'h0050_0093);
            load_word(d, 8'd4,   32'h1111_2222);
            load_word(d, 8'd0,   32'hA000_0000);
            load_word(d, 8'd1,   32'hA000_0001);
            load_word(d, 8'd2,   32'hA000_0002);
            load_word(d, 8'd255, 32'hCAFE_00FF);

            fetch(d, 32'h0000_000C, 32'h0050_0093, 1'b0, "basic");
            test_backpressure(d);
            test_b2b(d);
            fetch(d, 32'h0000_0006, 32'h0000_0013, 1'b1, "misalign");
            fetch(d, 32'h0000_0400, 32'h0000_0013, 1'b1, "range");
            fetch(d, 32'h8000_0000, 32'h0000_0013, 1'b1, "range hi");
            fetch(d, 32'h0000_03FC, 32'hCAFE_00FF, 1'b0, "last word");
            test_collision(d);
        end

        test_reset(0);
        test_reset(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
